// File: rtl/mem_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bist_ctrl
//  Description : March-style built-in self-test sequencer for a single-port
//                synchronous RAM (cs/wr/rd strobes, one-cycle registered read).
//                Four passes: write P(a), read/compare P(a), write ~P(a),
//                read/compare ~P(a).  Reports pass/fail, a saturating
//                miscompare count and the first failing address/data.
//  Ports       :
//    clk               single clock, all state changes on posedge
//    rst               asynchronous active-high reset
//    start_i           begin a test (sampled only while idle)
//    mem_addr_o        RAM address
//    mem_wdata_o       RAM write data
//    mem_cs_o          RAM chip select
//    mem_wr_o          RAM write enable
//    mem_rd_o          RAM read enable
//    mem_rdata_i       RAM read data, valid the cycle after rd is sampled
//    busy_o            test in progress
//    done_o            test finished (held until next accepted start / rst)
//    pass_o            valid with done_o; 1 = no miscompares
//    err_count_o       saturating miscompare count
//    first_err_addr_o  address of the first miscompare
//    first_err_data_o  read data of the first miscompare
//  Revision    : 1.0  initial release
// ============================================================================
module mem_bist_ctrl #(
    parameter int              AW   = 10,
    parameter int              DW   = 8,
    parameter logic [DW-1:0]   SEED = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    output logic            mem_cs_o,
    output logic            mem_wr_o,
    output logic            mem_rd_o,
    input  logic [DW-1:0]   mem_rdata_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            pass_o,
    output logic [AW:0]     err_count_o,
    output logic [AW-1:0]   first_err_addr_o,
    output logic [DW-1:0]   first_err_data_o
);

    localparam logic [AW-1:0] C_LAST    = {AW{1'b1}};
    localparam logic [AW:0]   C_ERR_MAX = {(AW+1){1'b1}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_W0   = 3'd1,
        S_R0   = 3'd2,
        S_D0   = 3'd3,
        S_W1   = 3'd4,
        S_R1   = 3'd5,
        S_D1   = 3'd6,
        S_FIN  = 3'd7
    } state_t;

    // Pattern: low DW address bits (zero-extended when AW < DW) xor SEED,
    // optionally inverted for the second write/read pair.
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input logic inv);
        logic [AW+DW-1:0] ext;
        ext = {{DW{1'b0}}, a};
        return ext[DW-1:0] ^ SEED ^ {DW{inv}};
    endfunction

    state_t          state_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic            cs_q;
    logic            wr_q;
    logic            rd_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [AW:0]     err_count_q;
    logic [AW-1:0]   first_err_addr_q;
    logic [DW-1:0]   first_err_data_q;

    // Compare pipeline stage: captured when a read is issued, checked the
    // following cycle when the RAM has returned the data.
    logic            chk_v_q;
    logic [AW-1:0]   chk_addr_q;
    logic [DW-1:0]   chk_exp_q;

    logic            miscmp_d;
    logic [AW:0]     err_count_d;
    logic [AW-1:0]   first_err_addr_d;
    logic [DW-1:0]   first_err_data_d;

    always_comb begin
        miscmp_d         = chk_v_q && (mem_rdata_i != chk_exp_q);
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        first_err_data_d = first_err_data_q;
        if (miscmp_d) begin
            if (err_count_q != C_ERR_MAX) begin
                err_count_d = err_count_q + 1'b1;
            end
            // A zero count means no earlier miscompare in this run; the
            // count saturates rather than wrapping so this stays exact.
            if (err_count_q == '0) begin
                first_err_addr_d = chk_addr_q;
                first_err_data_d = mem_rdata_i;
            end
        end
    end

    // Single sequential block: every output is registered and loaded with
    // the value belonging to the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            addr_q           <= '0;
            wdata_q          <= '0;
            cs_q             <= 1'b0;
            wr_q             <= 1'b0;
            rd_q             <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            first_err_data_q <= '0;
            chk_v_q          <= 1'b0;
            chk_addr_q       <= '0;
            chk_exp_q        <= '0;
        end else begin
            chk_v_q          <= rd_q;
            chk_addr_q       <= addr_q;
            chk_exp_q        <= pat(addr_q, state_q == S_R1);
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            first_err_data_q <= first_err_data_d;

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q          <= S_W0;
                        addr_q           <= '0;
                        wdata_q          <= pat('0, 1'b0);
                        cs_q             <= 1'b1;
                        wr_q             <= 1'b1;
                        rd_q             <= 1'b0;
                        busy_q           <= 1'b1;
                        done_q           <= 1'b0;
                        pass_q           <= 1'b0;
                        err_count_q      <= '0;
                        first_err_addr_q <= '0;
                        first_err_data_q <= '0;
                    end
                end
                S_W0, S_W1: begin
                    if (addr_q == C_LAST) begin
                        state_q <= (state_q == S_W0) ? S_R0 : S_R1;
                        addr_q  <= '0;
                        wr_q    <= 1'b0;
                        rd_q    <= 1'b1;
                    end else begin
                        addr_q  <= addr_q + 1'b1;
                        wdata_q <= pat(addr_q + 1'b1, state_q == S_W1);
                    end
                end
                S_R0, S_R1: begin
                    if (addr_q == C_LAST) begin
                        state_q <= (state_q == S_R0) ? S_D0 : S_D1;
                        cs_q    <= 1'b0;
                        rd_q    <= 1'b0;
                    end else begin
                        addr_q  <= addr_q + 1'b1;
                    end
                end
                S_D0: begin
                    state_q <= S_W1;
                    addr_q  <= '0;
                    wdata_q <= pat('0, 1'b1);
                    cs_q    <= 1'b1;
                    wr_q    <= 1'b1;
                end
                S_D1: begin
                    state_q <= S_FIN;
                end
                S_FIN: begin
                    // The last compare retired on the edge entering FIN, so
                    // the count is final here.
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (err_count_q == '0);
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr_o       = addr_q;
    assign mem_wdata_o      = wdata_q;
    assign mem_cs_o         = cs_q;
    assign mem_wr_o         = wr_q;
    assign mem_rd_o         = rd_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_count_o      = err_count_q;
    assign first_err_addr_o = first_err_addr_q;
    assign first_err_data_o = first_err_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bist_ctrl
//  Description : Self-checking bench for mem_bist_ctrl with a behavioural
//                RAM that can inject read faults.  Expected RAM accesses and
//                end-of-run results are queued when a run is started and
//                popped as the design produces them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_bist_ctrl;

    localparam int            AW    = 10;
    localparam int            DW    = 8;
    localparam int            DEPTH = 1 << AW;
    localparam logic [DW-1:0] SEED  = 8'hA5;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_cs;
    logic            mem_wr;
    logic            mem_rd;
    logic [DW-1:0]   mem_rdata;
    logic            busy;
    logic            done;
    logic            pass;
    logic [AW:0]     err_count;
    logic [AW-1:0]   first_err_addr;
    logic [DW-1:0]   first_err_data;

    always #5 clk = ~clk;

    mem_bist_ctrl #(.AW(AW), .DW(DW), .SEED(SEED)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start),
        .mem_addr_o       (mem_addr),
        .mem_wdata_o      (mem_wdata),
        .mem_cs_o         (mem_cs),
        .mem_wr_o         (mem_wr),
        .mem_rd_o         (mem_rd),
        .mem_rdata_i      (mem_rdata),
        .busy_o           (busy),
        .done_o           (done),
        .pass_o           (pass),
        .err_count_o      (err_count),
        .first_err_addr_o (first_err_addr),
        .first_err_data_o (first_err_data)
    );

    // ------------------------------------------------------------------
    // RAM model. fault_mode: 0 ideal, 1 addr 5 bit0 stuck-at-0, 2 rdata=0
    // ------------------------------------------------------------------
    logic [DW-1:0] ram [DEPTH];
    int            fault_mode = 0;

    function automatic logic [DW-1:0] fault(input logic [AW-1:0] a, input logic [DW-1:0] v);
        if (fault_mode == 2) return '0;
        if (fault_mode == 1 && a == 5) return v & 8'hFE;
        return v;
    endfunction

    always @(posedge clk) begin
        if (mem_cs && mem_wr) ram[mem_addr] <= mem_wdata;
        if (mem_cs && mem_rd) mem_rdata <= fault(mem_addr, ram[mem_addr]);
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct packed {
        logic            wr;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
    } acc_t;

    typedef struct packed {
        logic            pass;
        logic [AW:0]     cnt;
        logic [AW-1:0]   fa;
        logic [DW-1:0]   fd;
    } res_t;

    acc_t acc_q[$];
    res_t res_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] p_of(input int a, input bit inv);
        logic [DW-1:0] v;
        v = a[DW-1:0] ^ SEED;
        return inv ? ~v : v;
    endfunction

    // Queue the expected access stream and final result for one full run.
    task automatic push_expected();
        res_t r;
        logic [DW-1:0] e;
        logic [DW-1:0] got;
        r = '0;
        for (int ps = 0; ps < 4; ps++) begin
            for (int a = 0; a < DEPTH; a++) begin
                acc_t x;
                x.wr   = (ps == 0 || ps == 2);
                x.addr = a[AW-1:0];
                x.data = x.wr ? p_of(a, ps == 2) : '0;
                acc_q.push_back(x);
                if (!x.wr) begin
                    e   = p_of(a, ps == 3);
                    got = fault(a[AW-1:0], e);
                    if (got != e) begin
                        if (r.cnt == 0) begin
                            r.fa = a[AW-1:0];
                            r.fd = got;
                        end
                        if (r.cnt != {(AW+1){1'b1}}) r.cnt = r.cnt + 1'b1;
                    end
                end
            end
        end
        r.pass = (r.cnt == 0);
        res_q.push_back(r);
    endtask

    // Per-cycle protocol and access-order checks.
    always @(negedge clk) begin
        if (!rst) begin
            chk("wr_and_rd", 32'(mem_wr & mem_rd), 32'd0);
            chk("cs_eq_wr_or_rd", 32'(mem_cs), 32'(mem_wr | mem_rd));
            if (mem_cs) begin
                chk("access_expected", 32'(acc_q.size() > 0), 32'd1);
                if (acc_q.size() > 0) begin
                    acc_t x;
                    x = acc_q.pop_front();
                    chk("acc_wr", 32'(mem_wr), 32'(x.wr));
                    chk("acc_addr", 32'(mem_addr), 32'(x.addr));
                    if (x.wr) chk("acc_wdata", 32'(mem_wdata), 32'(x.data));
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_addr"},  32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_ctrl"},  32'({mem_cs, mem_wr, mem_rd}), 32'd0);
        chk({tag, "_stat"},  32'({busy, done, pass}), 32'd0);
        chk({tag, "_errcnt"}, 32'(err_count), 32'd0);
        chk({tag, "_fa"},    32'(first_err_addr), 32'd0);
        chk({tag, "_fd"},    32'(first_err_data), 32'd0);
    endtask

    // One run: optional second start at edge 100, optional reset mid-R0.
    task automatic run(input int mode, input bit restart, input bit abort);
        int   cyc;
        res_t r;
        fault_mode = mode;
        push_expected();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_clears", 32'({done, pass, err_count}), 32'd0);
        cyc = 0;
        while (cyc < 6000) begin
            @(posedge clk);
            cyc++;
            #1;
            if (restart && cyc == 99) start = 1'b1;
            if (restart && cyc == 100) start = 1'b0;
            if (abort && cyc == 1500) begin
                #2;
                rst = 1'b1;
                #1;
                check_all_zero("abort");
                acc_q.delete();
                res_q.delete();
                repeat (2) @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (done) break;
        end
        chk("run_edges", 32'(cyc), 32'd4099);
        chk("leftover_access", 32'(acc_q.size()), 32'd0);
        acc_q.delete();
        r = res_q.pop_front();
        chk("pass", 32'(pass), 32'(r.pass));
        chk("err_count", 32'(err_count), 32'(r.cnt));
        chk("first_err_addr", 32'(first_err_addr), 32'(r.fa));
        chk("first_err_data", 32'(first_err_data), 32'(r.fd));
        chk("busy_after", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_held", 32'({done, busy, mem_cs}), 32'b100);
        chk("pass_held", 32'(pass), 32'(r.pass));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        run(0, 1'b0, 1'b0);     // ideal RAM
        run(1, 1'b0, 1'b0);     // addr 5 bit0 stuck-at-0
        run(2, 1'b0, 1'b0);     // read data tied low
        run(0, 1'b1, 1'b0);     // start pulsed mid-run is ignored
        run(0, 1'b0, 1'b1);     // reset mid-R0
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("post_abort");
        run(0, 1'b0, 1'b0);     // clean run after abort
        run(0, 1'b0, 1'b0);     // back-to-back

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
